// File: rtl/string_accel_pkg.sv
// Shared types and constants for the Avalon-MM string accelerator.
// Optional IRQ output is enabled by defining STRING_ACCEL_IRQ_EN.
package string_accel_pkg;

    typedef enum logic [2:0] {
        OP_COPY    = 3'd0,
        OP_UPPER   = 3'd1,
        OP_CMP     = 3'd2,
        OP_FIND    = 3'd3,
        OP_REVERSE = 3'd4
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    localparam logic [1:0] REGION_A   = 2'b00;
    localparam logic [1:0] REGION_B   = 2'b01;
    localparam logic [1:0] REGION_R   = 2'b10;
    localparam logic [1:0] REGION_CSR = 2'b11;

    localparam int CSR_CTRL   = 0;
    localparam int CSR_STATUS = 1;
    localparam int CSR_SCALAR = 2;

    localparam int CTRL_GO         = 0;
    localparam int CTRL_OP_LSB     = 1;
    localparam int CTRL_IRQ_EN     = 4;
    localparam int CTRL_INDEX_LSB  = 8;
    localparam int CTRL_LENGTH_LSB = 16;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;
    localparam int STAT_ERR  = 2;

    localparam logic [31:0] NOT_FOUND = 32'hFFFF_FFFF;

    function automatic logic [7:0] to_upper(input logic [7:0] c);
        return (c >= 8'h61 && c <= 8'h7A) ? (c - 8'h20) : c;
    endfunction

endpackage

// File: rtl/string_accel_core.sv
// Byte-serial engine: FSM, byte counter, result buffer R and SCALAR.
// Reads A/B one byte per cycle through combinational address/data ports.
module string_accel_core
    import string_accel_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int IDX_W  = $clog2(MAX_LEN)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [2:0]             op_i,
    input  logic [7:0]             index_i,
    input  logic [7:0]             length_i,
    input  logic                   clr_done_i,
    input  logic                   clr_err_i,
    output logic [IDX_W-1:0]       a_addr_o,
    output logic [IDX_W-1:0]       b_addr_o,
    input  logic [7:0]             a_byte_i,
    input  logic [7:0]             b_byte_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   done_d_o,
    output logic                   err_o,
    output logic [8*MAX_LEN-1:0]   r_o,
    output logic [31:0]            scalar_o
);

    state_t      state_q;
    op_t         op_q;
    logic [7:0]  index_q, len_q, k_q;
    logic [31:0] scalar_q;
    logic [7:0]  r_q [MAX_LEN];
    logic        done_q, done_d, err_q, err_d;

    logic [8:0]  range_sum;
    logic        bad_req;
    logic [7:0]  a_off;
    logic [8:0]  a_pos;
    logic        last, stop;

    assign range_sum = {1'b0, index_i} + {1'b0, length_i};
    assign bad_req   = (range_sum > 9'(MAX_LEN)) || (op_i > 3'd4);

    // REVERSE walks A from the far end of the substring
    assign a_off    = (op_q == OP_REVERSE) ? (len_q - 8'd1 - k_q) : k_q;
    assign a_pos    = {1'b0, index_q} + {1'b0, a_off};
    assign a_addr_o = a_pos[IDX_W-1:0];
    assign b_addr_o = (op_q == OP_FIND) ? '0 : k_q[IDX_W-1:0];

    assign last = (k_q == len_q - 8'd1);
    assign stop = last
               || (op_q == OP_CMP  && a_byte_i != b_byte_i)
               || (op_q == OP_FIND && a_byte_i == b_byte_i);

    always_comb begin
        done_d = done_q;
        err_d  = err_q;
        if (clr_done_i) done_d = 1'b0;
        if (clr_err_i)  err_d  = 1'b0;
        if (state_q == ST_IDLE && start_i) begin
            done_d = 1'b0;
            err_d  = bad_req;
        end
        if (state_q == ST_FIN) done_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_COPY;
            index_q  <= '0;
            len_q    <= '0;
            k_q      <= '0;
            scalar_q <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) r_q[i] <= '0;
        end else begin
            done_q <= done_d;
            err_q  <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        for (int i = 0; i < MAX_LEN; i++) r_q[i] <= '0;
                        scalar_q <= (!bad_req && length_i == 8'd0 && op_i == OP_FIND)
                                    ? NOT_FOUND : 32'd0;
                        op_q     <= op_t'(op_i);
                        index_q  <= index_i;
                        len_q    <= length_i;
                        k_q      <= '0;
                        state_q  <= (bad_req || length_i == 8'd0) ? ST_FIN : ST_RUN;
                    end
                end
                ST_RUN: begin
                    case (op_q)
                        OP_COPY, OP_REVERSE: r_q[k_q[IDX_W-1:0]] <= a_byte_i;
                        OP_UPPER:            r_q[k_q[IDX_W-1:0]] <= to_upper(a_byte_i);
                        OP_CMP: begin
                            if (a_byte_i != b_byte_i)
                                scalar_q <= (a_byte_i > b_byte_i) ? 32'd1 : NOT_FOUND;
                        end
                        OP_FIND: begin
                            if (a_byte_i == b_byte_i) scalar_q <= 32'(a_pos);
                            else if (last)            scalar_q <= NOT_FOUND;
                        end
                        default: ;
                    endcase
                    k_q     <= k_q + 8'd1;
                    state_q <= stop ? ST_FIN : ST_RUN;
                end
                ST_FIN:  state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_r_flat
        assign r_o[8*gi +: 8] = r_q[gi];
    end

    assign busy_o   = (state_q != ST_IDLE);
    assign done_o   = done_q;
    assign done_d_o = done_d;
    assign err_o    = err_q;
    assign scalar_o = scalar_q;

endmodule

// File: rtl/string_accel_avmm.sv
// Avalon-MM slave top: address decode, A/B word buffers, CSRs, readdata.
// Define STRING_ACCEL_IRQ_EN to add the irq output and the CTRL irq_en bit.
module string_accel_avmm
    import string_accel_pkg::*;
#(
    parameter int MAX_LEN = 16,
    localparam int W      = MAX_LEN / 4,
    localparam int ADDR_W = $clog2(W) + 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata
`ifdef STRING_ACCEL_IRQ_EN
    ,
    output logic              irq
`endif
);

    localparam int WORD_W = ADDR_W - 2;
    localparam int IDX_W  = $clog2(MAX_LEN);

    logic [31:0]        a_q [W];
    logic [31:0]        b_q [W];
    logic [2:0]         ctrl_op_q;
    logic [7:0]         ctrl_index_q, ctrl_len_q;
    logic [31:0]        readdata_q, rd_word;
    logic               irq_en_bit;

    logic [1:0]         region;
    logic [WORD_W-1:0]  word;
    logic               wr_sel, rd_sel, csr_wr, ctrl_wr, start, clr_done, clr_err;

    logic [IDX_W-1:0]   a_addr, b_addr;
    logic [7:0]         a_byte, b_byte;
    logic               busy, done, done_d, err;
    logic [8*MAX_LEN-1:0] r_flat;
    logic [31:0]        scalar;

    assign region   = address[ADDR_W-1 -: 2];
    assign word     = address[WORD_W-1:0];
    assign wr_sel   = chipselect && write;
    assign rd_sel   = chipselect && read && !write;
    assign csr_wr   = wr_sel && region == REGION_CSR;
    assign ctrl_wr  = csr_wr && word == WORD_W'(CSR_CTRL) && !busy;
    assign start    = ctrl_wr && writedata[CTRL_GO];
    // STATUS clears are honoured even while the engine is busy
    assign clr_done = csr_wr && word == WORD_W'(CSR_STATUS) && writedata[STAT_DONE];
    assign clr_err  = csr_wr && word == WORD_W'(CSR_STATUS) && writedata[STAT_ERR];

    assign a_byte = a_q[a_addr[IDX_W-1:2]][{a_addr[1:0], 3'b000} +: 8];
    assign b_byte = b_q[b_addr[IDX_W-1:2]][{b_addr[1:0], 3'b000} +: 8];

    string_accel_core #(.MAX_LEN(MAX_LEN)) u_core (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .op_i       (writedata[CTRL_OP_LSB +: 3]),
        .index_i    (writedata[CTRL_INDEX_LSB +: 8]),
        .length_i   (writedata[CTRL_LENGTH_LSB +: 8]),
        .clr_done_i (clr_done),
        .clr_err_i  (clr_err),
        .a_addr_o   (a_addr),
        .b_addr_o   (b_addr),
        .a_byte_i   (a_byte),
        .b_byte_i   (b_byte),
        .busy_o     (busy),
        .done_o     (done),
        .done_d_o   (done_d),
        .err_o      (err),
        .r_o        (r_flat),
        .scalar_o   (scalar)
    );

`ifdef STRING_ACCEL_IRQ_EN
    logic irq_en_q, irq_en_d, irq_q;
    assign irq_en_d   = ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en_q;
    assign irq_en_bit = irq_en_q;
    assign irq        = irq_q;

    // Built from next-state values so irq rises in the same cycle as done
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= done_d && irq_en_d;
        end
    end
`else
    assign irq_en_bit = 1'b0;
`endif

    always_comb begin
        rd_word = '0;
        case (region)
            REGION_A: rd_word = a_q[word];
            REGION_B: rd_word = b_q[word];
            REGION_R: rd_word = r_flat[32*word +: 32];
            default: begin
                if (word == WORD_W'(CSR_CTRL))
                    rd_word = {8'h00, ctrl_len_q, ctrl_index_q, 3'b000, irq_en_bit, ctrl_op_q, 1'b0};
                else if (word == WORD_W'(CSR_STATUS))
                    rd_word = {29'd0, err, done, busy};
                else if (word == WORD_W'(CSR_SCALAR))
                    rd_word = scalar;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < W; i++) begin
                a_q[i] <= '0;
                b_q[i] <= '0;
            end
            ctrl_op_q    <= '0;
            ctrl_index_q <= '0;
            ctrl_len_q   <= '0;
            readdata_q   <= '0;
        end else begin
            if (wr_sel && !busy && region == REGION_A) a_q[word] <= writedata;
            if (wr_sel && !busy && region == REGION_B) b_q[word] <= writedata;
            if (ctrl_wr) begin
                ctrl_op_q    <= writedata[CTRL_OP_LSB +: 3];
                ctrl_index_q <= writedata[CTRL_INDEX_LSB +: 8];
                ctrl_len_q   <= writedata[CTRL_LENGTH_LSB +: 8];
            end
            if (rd_sel) readdata_q <= rd_word;
        end
    end

    assign readdata = readdata_q;

endmodule

// File: doc/string_accel_avmm.md
# string_accel_avmm

Parametrised Avalon-MM slave string accelerator for the Nios II system and the next generation of the single-word string engine. It holds two MAX_LEN-byte operand buffers (A, B) and a MAX_LEN-byte result buffer (R). It runs one of five byte-serial operations (copy, upper-case, compare, find, reverse) over a substring of A, using a go/busy/done handshake. The CPU loads the buffers, writes CTRL, then polls STATUS (or takes the IRQ) and reads R or SCALAR.

## Interface
- MAX_LEN, 16: bytes per buffer; multiple of 4, 16..256.
- W (localparam), MAX_LEN/4: words per buffer.
- ADDR_W (localparam), $clog2(W)+2: word-address width.
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- chipselect  in  1  slave select.
- read  in  1  read strobe.
- write  in  1  write strobe.
- address  in  ADDR_W  word address.
- writedata  in  32  write data.
- readdata  out  32  registered read data; fixed read latency 1; reset 0.
- irq  out  1  interrupt; present only with STRING_ACCEL_IRQ_EN; reset 0.

## Operation
- Address map, selected by address[ADDR_W-1:ADDR_W-2]:
  - 00: A words 0..W-1.
  - 01: B words.
  - 10: R words (read-only).
  - 11: CSR. Offset 0 CTRL, 1 STATUS, 2 SCALAR (read-only); other offsets read 0 and ignore writes.
- Byte k of a buffer sits in word k/4, bits [8(k%4)+7 : 8(k%4)] (little-endian).
- CTRL fields:
  - [0] go: write-1 starts an operation; self-clears and always reads 0.
  - [3:1] op.
  - [4] irq_en.
  - [15:8] index.
  - [23:16] length.
  - Other bits read 0.
- STATUS fields: [0] busy, [1] done (sticky), [2] err (sticky). Writing 1 to bit 1 or bit 2 clears that bit.
- FSM states IDLE, RUN, FIN.
- IDLE → RUN on a CTRL write with go=1. At acceptance:
  - R and SCALAR clear to 0; done and err clear.
  - op, index and length latch; byte counter k resets to 0.
- Range check at acceptance: if index+length > MAX_LEN (9-bit sum) or op > 4, go straight to FIN with err=1 and R=0.
- RUN processes byte k per cycle, k = 0..length-1:
  - op 0 COPY: R[k] = A[index+k].
  - op 1 UPPER: R[k] = A[index+k] - 0x20 when the byte is 0x61..0x7A; otherwise unchanged.
  - op 2 CMP: compares A[index+k] with B[k] as unsigned bytes. On the first mismatch, SCALAR = 1 (A greater) or 0xFFFFFFFF (A smaller), then FIN. All bytes equal → SCALAR = 0.
  - op 3 FIND: searches for B[0]. On the first A[index+k] == B[0], SCALAR = index+k, then FIN. No match → SCALAR = 0xFFFFFFFF.
  - op 4 REVERSE: R[k] = A[index+length-1-k].
- RUN → FIN after byte length-1, or on early exit. length = 0 goes straight to FIN; FIND then gives SCALAR = 0xFFFFFFFF, others 0.
- FIN sets done=1, returns to IDLE.
- busy = 1 in RUN and FIN.
- While busy:
  - Writes to A, B and CTRL are ignored, including go.
  - STATUS clear-writes are honoured.
  - Reads of R return partial contents.
- Write and read in the same selected cycle: the write is performed, readdata holds its previous value.
- Reset at any time: IDLE; all buffers, CSRs and readdata return to 0.

## Timing
- Go written in cycle T: busy=1 from T+1.
- Byte k is processed in cycle T+1+k; FIN is in cycle T+1+N, where N = bytes processed.
- done=1 and busy=0 are visible from T+2+N.
- Error or length=0 case: done visible from T+2.
- Read issued in cycle T: readdata is valid in T+1 and holds until the next read.

## Configuration
- STRING_ACCEL_IRQ_EN defined:
  - irq port is present; irq = done & irq_en, registered, so it asserts the same cycle done becomes visible.
  - Clearing done or irq_en deasserts irq the next cycle.
- STRING_ACCEL_IRQ_EN undefined: no irq port; CTRL[4] is not stored and reads 0.

## Structure
- Package string_accel_pkg holds:
  - op_t enum (COPY, UPPER, CMP, FIND, REVERSE).
  - state_t enum (IDLE, RUN, FIN).
  - Region codes, CSR offsets, CTRL/STATUS bit positions.
  - NOT_FOUND constant, 32'hFFFFFFFF.
- Sub-module string_accel_core holds the FSM, counter and byte datapath, with start/op/index/length in and busy/done/err/R/SCALAR out.
- The top level holds the Avalon decode, the buffers and readdata.

## Test plan
- MAX_LEN=16, A="Hello, World!xyz", CTRL op=COPY, index=7, length=5 → done at T+7; R word0=0x6C726F57, word1=0x00000064.
- Same A, op=UPPER, index=0, length=5 → R bytes "HELLO"; STATUS=0x2.
- A="abcd...", B="abcx", op=CMP, index=0, length=4 → SCALAR=0xFFFFFFFF, done at T+6; with B="abcd" → SCALAR=0.
- op=FIND, B[0]='o', index=5, length=8 on "Hello, World!" → SCALAR=8; search for 'q' → 0xFFFFFFFF after 8 bytes.
- index=12, length=5 → err=1, done at T+2, R=0. A second go written during a length-16 run is ignored. reset asserted mid-RUN → STATUS=0, readdata=0.
- With STRING_ACCEL_IRQ_EN, irq_en=1 → irq rises with done; a write of 0x2 to STATUS drops irq one cycle later.
